// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer arbiter: phase encoding, default widths
// and read-port client identifiers.
package fb_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int DIM_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PROCESS = 2'd2,
        DISPLAY = 2'd3
    } phase_t;

    localparam logic [1:0] CLI_NONE  = 2'd0;
    localparam logic [1:0] CLI_SOBEL = 2'd1;
    localparam logic [1:0] CLI_VGA   = 2'd2;

endpackage

// File: rtl/fb_addr_gen.sv
// Registered row*width+col address unit. When FB_OOB_CHECK_EN is defined and CHECK
// is set, out-of-frame coordinates yield address 0 and a one-cycle oob flag.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int AW    = fb_pkg::ADDR_W,
    parameter int DW    = fb_pkg::DIM_W,
    parameter bit CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] row,
    input  logic [DW-1:0] col,
    input  logic [DW-1:0] img_w,
    input  logic [DW-1:0] img_h,
    output logic [AW-1:0] addr,
    output logic          oob
);

    logic [2*DW-1:0] prod_s;
    logic            oob_s;

    // Full-width product plus unsigned column; truncation happens at the register
    always_comb begin
        prod_s = (2*DW)'(row) * (2*DW)'(img_w) + (2*DW)'(col);
    end

`ifdef FB_OOB_CHECK_EN
    assign oob_s = CHECK && ((row >= img_h) || (col >= img_w));
`else
    logic unused_s;
    assign unused_s = ^{img_h, CHECK};
    assign oob_s    = 1'b0;
`endif

    // Address register holds its value between requests; oob is a per-request pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= {AW{1'b0}};
            oob  <= 1'b0;
        end else if (en) begin
            addr <= oob_s ? {AW{1'b0}} : AW'(prod_s);
            oob  <= oob_s;
        end else begin
            oob  <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Frame-level LOAD/PROCESS/DISPLAY sequencer and read-port arbiter for the shared
// frame-buffer BRAM. Optional read range checking is enabled by FB_OOB_CHECK_EN.
module frame_buffer_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W = fb_pkg::ADDR_W,
    parameter int DATA_W = fb_pkg::DATA_W,
    parameter int DIM_W  = fb_pkg::DIM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [DIM_W-1:0]  img_w,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              sobel_req,
    input  logic [DIM_W-1:0]  sobel_row,
    input  logic [DIM_W-1:0]  sobel_col,
    output logic              sobel_gnt,
    output logic              sobel_rvalid,
    input  logic              sobel_done,
    input  logic              vga_req,
    input  logic [DIM_W-1:0]  vga_row,
    input  logic [DIM_W-1:0]  vga_col,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_wr_addr,
    output logic [DATA_W-1:0] bram_wr_data,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic [1:0]        phase,
    output logic              load_done,
    output logic              err
);

    phase_t           phase_r;
    logic [DIM_W-1:0] img_h_r, img_w_r, wrow_r, wcol_r;
    logic [DIM_W-1:0] rd_row_s, rd_col_s;
    logic [1:0]       gnt_cli_s, tag1_r;
    logic             wr_fire_s, last_px_s, start_ok_s, dims_ok_s;
    logic             rd_en_s, rd_oob_s, wr_oob_s;

    assign phase      = phase_r;
    assign wr_fire_s  = wr_valid && wr_ready;
    assign last_px_s  = wr_fire_s && (wrow_r == img_h_r - DIM_W'(1)) && (wcol_r == img_w_r - DIM_W'(1));
    assign start_ok_s = start && ((phase_r == IDLE) || (phase_r == DISPLAY));
    assign dims_ok_s  = (img_h != {DIM_W{1'b0}}) && (img_w != {DIM_W{1'b0}});

    // Fixed-priority read grant; DISPLAY reserves the port for VGA
    always_comb begin
        sobel_gnt = 1'b0;
        vga_gnt   = 1'b0;
        case (phase_r)
            PROCESS: begin
                sobel_gnt = sobel_req;
                vga_gnt   = vga_req && !sobel_req;
            end
            DISPLAY: begin
                vga_gnt   = vga_req;
            end
            default: begin
                sobel_gnt = 1'b0;
                vga_gnt   = 1'b0;
            end
        endcase
    end

    // Route the winning client's coordinates to the read address unit
    always_comb begin
        rd_en_s = sobel_gnt || vga_gnt;
        if (sobel_gnt) begin
            rd_row_s  = sobel_row;
            rd_col_s  = sobel_col;
            gnt_cli_s = CLI_SOBEL;
        end else if (vga_gnt) begin
            rd_row_s  = vga_row;
            rd_col_s  = vga_col;
            gnt_cli_s = CLI_VGA;
        end else begin
            rd_row_s  = {DIM_W{1'b0}};
            rd_col_s  = {DIM_W{1'b0}};
            gnt_cli_s = CLI_NONE;
        end
    end

    // Phase sequencer with frame dimensions and the column-first write pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r  <= IDLE;
            img_h_r  <= {DIM_W{1'b0}};
            img_w_r  <= {DIM_W{1'b0}};
            wrow_r   <= {DIM_W{1'b0}};
            wcol_r   <= {DIM_W{1'b0}};
            wr_ready <= 1'b0;
        end else begin
            case (phase_r)
                IDLE, DISPLAY: begin
                    if (start && dims_ok_s) begin
                        img_h_r  <= img_h;
                        img_w_r  <= img_w;
                        wrow_r   <= {DIM_W{1'b0}};
                        wcol_r   <= {DIM_W{1'b0}};
                        phase_r  <= LOAD;
                        wr_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (wr_fire_s) begin
                        if (wcol_r == img_w_r - DIM_W'(1)) begin
                            wcol_r <= {DIM_W{1'b0}};
                            wrow_r <= wrow_r + DIM_W'(1);
                        end else begin
                            wcol_r <= wcol_r + DIM_W'(1);
                        end
                        if (last_px_s) begin
                            phase_r  <= PROCESS;
                            wr_ready <= 1'b0;
                        end
                    end
                end
                PROCESS: begin
                    if (sobel_done) begin
                        phase_r <= DISPLAY;
                    end
                end
                default: begin
                    phase_r  <= IDLE;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error: a legal start clears it, a zero dimension or bad read sets it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (start_ok_s && dims_ok_s) begin
            err <= 1'b0;
        end else if ((start_ok_s && !dims_ok_s) || rd_oob_s || wr_oob_s) begin
            err <= 1'b1;
        end
    end

    // Write-side registers aligned with the write address unit output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bram_we      <= 1'b0;
            bram_wr_data <= {DATA_W{1'b0}};
            load_done    <= 1'b0;
        end else begin
            bram_we      <= wr_fire_s;
            load_done    <= last_px_s;
            if (wr_fire_s) begin
                bram_wr_data <= wr_data;
            end
        end
    end

    // Two-stage client tag pipe; data is squashed to zero for out-of-range reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag1_r       <= CLI_NONE;
            sobel_rvalid <= 1'b0;
            vga_rvalid   <= 1'b0;
            rd_data      <= {DATA_W{1'b0}};
        end else begin
            tag1_r       <= gnt_cli_s;
            sobel_rvalid <= (tag1_r == CLI_SOBEL);
            vga_rvalid   <= (tag1_r == CLI_VGA);
            rd_data      <= rd_oob_s ? {DATA_W{1'b0}} : bram_rd_data;
        end
    end

    fb_addr_gen #(.AW(ADDR_W), .DW(DIM_W), .CHECK(1'b0)) u_wr_addr (
        .clk   (clk),
        .reset (reset),
        .en    (wr_fire_s),
        .row   (wrow_r),
        .col   (wcol_r),
        .img_w (img_w_r),
        .img_h (img_h_r),
        .addr  (bram_wr_addr),
        .oob   (wr_oob_s)
    );

    fb_addr_gen #(.AW(ADDR_W), .DW(DIM_W), .CHECK(1'b1)) u_rd_addr (
        .clk   (clk),
        .reset (reset),
        .en    (rd_en_s),
        .row   (rd_row_s),
        .col   (rd_col_s),
        .img_w (img_w_r),
        .img_h (img_h_r),
        .addr  (bram_rd_addr),
        .oob   (rd_oob_s)
    );

endmodule
